// File: rtl/prog_stream_loader.sv
// Purpose: turns a little-endian byte stream into imem line / dmem word writes, then raises done.
// Latency: each write strobe and its addr/data appear one cycle after the word's last byte.
// Backpressure: never stalls while loading; in_ready drops only in the terminal DONE state.
module prog_stream_loader #(
  parameter int          ADDR_LEN       = 32,
  parameter int          IMEM_MAX_WORDS = 512,
  parameter int          DMEM_MAX_WORDS = 65536,
  parameter logic [31:0] DMEM_BASE      = 32'h0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  output logic                in_ready,
  output logic [ADDR_LEN-1:0] addr,
  output logic [127:0]        data,
  output logic                we_128,
  output logic                we_32,
  output logic                done,
  output logic                err
);

  typedef enum logic [2:0] {
    HDR_I  = 3'd0,
    HDR_D  = 3'd1,
    LOAD_I = 3'd2,
    LOAD_D = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            idx_q, idx_d;
  logic [31:0]           ni_q, ni_d;
  logic [31:0]           nd_q, nd_d;
  // Only bytes 0..14 are staged; byte 15 goes straight from in_data into data.
  logic [119:0]          stage_q, stage_d;
  logic [31:0]           line_q, line_d;
  logic [31:0]           word_q, word_d;
  logic [ADDR_LEN-1:0]   addr_q, addr_d;
  logic [127:0]          data_q, data_d;
  logic                  we128_q, we128_d;
  logic                  we32_q, we32_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  in_ready_q, in_ready_d;

  logic                  xfer;
  logic [31:0]           nd_full;
  logic [31:0]           dmem_word;
  logic [31:0]           addr_line;
  logic [31:0]           addr_word;

  assign xfer      = in_valid && in_ready_q;
  assign nd_full   = {in_data, nd_q[23:0]};
  assign dmem_word = {in_data, stage_q[23:0]};
  assign addr_line = line_q << 4;
  assign addr_word = DMEM_BASE + (word_q << 2);

  assign in_ready = in_ready_q;
  assign addr     = addr_q;
  assign data     = data_q;
  assign we_128   = we128_q;
  assign we_32    = we32_q;
  assign done     = done_q;
  assign err      = err_q;

  // State register and all datapath registers; reset aborts any partial word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= HDR_I;
      idx_q      <= 4'd0;
      ni_q       <= 32'd0;
      nd_q       <= 32'd0;
      stage_q    <= '0;
      line_q     <= 32'd0;
      word_q     <= 32'd0;
      addr_q     <= '0;
      data_q     <= '0;
      we128_q    <= 1'b0;
      we32_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ni_q       <= ni_d;
      nd_q       <= nd_d;
      stage_q    <= stage_d;
      line_q     <= line_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      we128_q    <= we128_d;
      we32_q     <= we32_d;
      done_q     <= done_d;
      err_q      <= err_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Next-state logic: header collection, word assembly, write strobe generation.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    ni_d     = ni_q;
    nd_d     = nd_q;
    stage_d  = stage_q;
    line_d   = line_q;
    word_d   = word_q;
    addr_d   = addr_q;
    data_d   = data_q;
    we128_d  = 1'b0;
    we32_d   = 1'b0;
    done_d   = done_q;
    err_d    = err_q;

    case (state_q)
      HDR_I: begin
        if (xfer) begin
          ni_d[{idx_q[1:0], 3'b000} +: 8] = in_data;
          idx_d = idx_q + 4'd1;
          if (idx_q[1:0] == 2'd3) begin
            idx_d   = 4'd0;
            state_d = HDR_D;
          end
        end
      end

      HDR_D: begin
        if (xfer) begin
          nd_d[{idx_q[1:0], 3'b000} +: 8] = in_data;
          idx_d = idx_q + 4'd1;
          if (idx_q[1:0] == 2'd3) begin
            idx_d = 4'd0;
            if ((ni_q > 32'(IMEM_MAX_WORDS)) || (nd_full > 32'(DMEM_MAX_WORDS))) begin
              state_d = DONE;
              err_d   = 1'b1;
              done_d  = 1'b1;
            end else if (ni_q != 32'd0) begin
              state_d = LOAD_I;
            end else if (nd_full != 32'd0) begin
              state_d = LOAD_D;
            end else begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
      end

      LOAD_I: begin
        if (xfer) begin
          idx_d = idx_q + 4'd1;
          if (idx_q != 4'd15) begin
            stage_d[{idx_q, 3'b000} +: 8] = in_data;
          end else begin
            data_d  = {in_data, stage_q};
            addr_d  = ADDR_LEN'(addr_line);
            we128_d = 1'b1;
            line_d  = line_q + 32'd1;
            if (line_q + 32'd1 == ni_q) begin
              if (nd_q != 32'd0) begin
                state_d = LOAD_D;
              end else begin
                state_d = DONE;
                done_d  = 1'b1;
              end
            end
          end
        end
      end

      LOAD_D: begin
        if (xfer) begin
          idx_d = idx_q + 4'd1;
          if (idx_q[1:0] != 2'd3) begin
            stage_d[{idx_q, 3'b000} +: 8] = in_data;
          end else begin
            idx_d  = 4'd0;
            data_d = {dmem_word, 96'd0};
            addr_d = ADDR_LEN'(addr_word);
            we32_d = 1'b1;
            word_d = word_q + 32'd1;
            if (word_q + 32'd1 == nd_q) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = DONE;
      end
    endcase

    in_ready_d = (state_d != DONE);
  end

endmodule

// File: tb/tb_prog_stream_loader.sv
module tb_prog_stream_loader;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic [31:0]  addr;
  logic [127:0] data;
  logic         we_128;
  logic         we_32;
  logic         done;
  logic         err;

  int tests;
  int fails;
  int cyc;
  int viol;
  logic prev_strobe;

  logic [127:0] log_data[$];
  logic [31:0]  log_addr[$];
  logic         log_imem[$];

  prog_stream_loader dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .addr     (addr),
    .data     (data),
    .we_128   (we_128),
    .we_32    (we_32),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe log plus checks on strobe exclusivity and single-cycle width.
  always @(negedge clk) begin
    if (reset) begin
      prev_strobe = 1'b0;
    end else begin
      if (we_128 && we_32) viol = viol + 1;
      if ((we_128 || we_32) && prev_strobe) viol = viol + 1;
      if (we_128 || we_32) begin
        log_data.push_back(data);
        log_addr.push_back(addr);
        log_imem.push_back(we_128);
      end
      prev_strobe = we_128 || we_32;
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_data  = 8'h00;
    #1;
    reset = 1'b1;
    idle(2);
    log_data.delete();
    log_addr.delete();
    log_imem.delete();
    viol  = 0;
    reset = 1'b0;
    idle(1);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (gap > 0) idle(gap);
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    logic [31:0] t;
    t = w;
    for (int k = 0; k < 4; k++) send_byte(t[8*k +: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  task automatic test_reset();
    in_valid = 1'b0;
    in_data  = 8'h00;
    reset    = 1'b1;
    #3;
    tests++;
    if ({in_ready, addr, data, we_128, we_32, done, err} !== 166'd0) begin
      fails++;
      $display("FAIL reset_outputs: got rdy=%b addr=%h data=%h we=%b%b done=%b err=%b, want all 0",
               in_ready, addr, data, we_128, we_32, done, err);
    end
    do_reset();
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: got in_ready=%b, want 1", in_ready);
    end
  endtask

  task automatic test_imem_one();
    do_reset();
    send_word(32'd1, 0);
    send_word(32'd0, 0);
    for (int k = 0; k < 16; k++) send_byte(8'(k), 0);
    tests++;
    if ({we_128, we_32, done, err} !== 4'b1010 || addr !== 32'h0 ||
        data !== 128'h0F0E0D0C0B0A09080706050403020100) begin
      fails++;
      $display("FAIL imem_one_strobe: got we128=%b we32=%b done=%b err=%b addr=%h data=%h, want 1 0 1 0 addr 0 data 0f0e..0100",
               we_128, we_32, done, err, addr, data);
    end
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL imem_one_ready: got in_ready=%b, want 0", in_ready);
    end
    idle(1);
    tests++;
    if (we_128 !== 1'b0 || done !== 1'b1 || data !== 128'h0F0E0D0C0B0A09080706050403020100 ||
        log_data.size() != 1) begin
      fails++;
      $display("FAIL imem_one_after: got we128=%b done=%b data=%h writes=%0d, want 0 1 held 1",
               we_128, done, data, log_data.size());
    end
  endtask

  task automatic test_dmem_two();
    do_reset();
    send_word(32'd0, 0);
    send_word(32'd2, 0);
    send_word(32'hDEADBEEF, 0);
    tests++;
    if (we_32 !== 1'b1 || we_128 !== 1'b0 || addr !== 32'h0 || data !== {32'hDEADBEEF, 96'd0} || done !== 1'b0) begin
      fails++;
      $display("FAIL dmem_word0: got we32=%b we128=%b addr=%h data=%h done=%b, want 1 0 0 deadbeef_0 0",
               we_32, we_128, addr, data, done);
    end
    send_byte(8'h01, 0);
    tests++;
    if (we_32 !== 1'b0 || addr !== 32'h0) begin
      fails++;
      $display("FAIL dmem_hold: got we32=%b addr=%h, want 0 0", we_32, addr);
    end
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    tests++;
    if (we_32 !== 1'b1 || addr !== 32'h4 || data !== {32'h00000001, 96'd0} || done !== 1'b1 || err !== 1'b0) begin
      fails++;
      $display("FAIL dmem_word1: got we32=%b addr=%h data=%h done=%b err=%b, want 1 4 00000001_0 1 0",
               we_32, addr, data, done, err);
    end
    idle(2);
    tests++;
    if (log_data.size() != 2 || log_imem[0] !== 1'b0 || log_imem[1] !== 1'b0) begin
      fails++;
      $display("FAIL dmem_no_imem: got writes=%0d, want 2 dmem-only", log_data.size());
    end
  endtask

  task automatic test_gaps();
    do_reset();
    send_word(32'd2, 2);
    send_word(32'd1, 2);
    for (int k = 0; k < 16; k++) send_byte(8'hA0 + 8'(k), int'($urandom_range(0, 2)));
    for (int k = 0; k < 16; k++) send_byte(8'hB0 + 8'(k), int'($urandom_range(0, 2)));
    send_word(32'h12345678, 2);
    idle(3);
    tests++;
    if (log_data.size() != 3) begin
      fails++;
      $display("FAIL gaps_count: got %0d writes, want 3", log_data.size());
    end else begin
      tests++;
      if (log_imem[0] !== 1'b1 || log_addr[0] !== 32'h0 || log_data[0] !== 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0) begin
        fails++;
        $display("FAIL gaps_line0: got imem=%b addr=%h data=%h, want 1 0 afae..a1a0", log_imem[0], log_addr[0], log_data[0]);
      end
      tests++;
      if (log_imem[1] !== 1'b1 || log_addr[1] !== 32'h10 || log_data[1] !== 128'hBFBEBDBCBBBAB9B8B7B6B5B4B3B2B1B0) begin
        fails++;
        $display("FAIL gaps_line1: got imem=%b addr=%h data=%h, want 1 10 bfbe..b1b0", log_imem[1], log_addr[1], log_data[1]);
      end
      tests++;
      if (log_imem[2] !== 1'b0 || log_addr[2] !== 32'h0 || log_data[2] !== {32'h12345678, 96'd0}) begin
        fails++;
        $display("FAIL gaps_word0: got imem=%b addr=%h data=%h, want 0 0 12345678_0", log_imem[2], log_addr[2], log_data[2]);
      end
    end
    tests++;
    if (done !== 1'b1 || err !== 1'b0 || viol != 0) begin
      fails++;
      $display("FAIL gaps_final: got done=%b err=%b strobe_violations=%0d, want 1 0 0", done, err, viol);
    end
  endtask

  task automatic test_err();
    do_reset();
    send_word(32'd513, 0);
    for (int k = 0; k < 3; k++) send_byte(8'h00, 0);
    tests++;
    if (done !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL err_early: got done=%b err=%b before 8th byte, want 0 0", done, err);
    end
    send_byte(8'h00, 0);
    tests++;
    if (done !== 1'b1 || err !== 1'b1 || in_ready !== 1'b0 || we_128 !== 1'b0 || we_32 !== 1'b0) begin
      fails++;
      $display("FAIL err_flag: got done=%b err=%b rdy=%b we=%b%b, want 1 1 0 00", done, err, in_ready, we_128, we_32);
    end
    idle(3);
    tests++;
    if (log_data.size() != 0) begin
      fails++;
      $display("FAIL err_no_writes: got %0d writes, want 0", log_data.size());
    end
  endtask

  task automatic test_empty();
    do_reset();
    send_word(32'd0, 0);
    for (int k = 0; k < 3; k++) send_byte(8'h00, 0);
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL empty_early: got done=%b after 7 bytes, want 0", done);
    end
    send_byte(8'h00, 0);
    tests++;
    if (done !== 1'b1 || err !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL empty_done: got done=%b err=%b rdy=%b, want 1 0 0", done, err, in_ready);
    end
    for (int k = 0; k < 6; k++) send_byte(8'h55, 0);
    tests++;
    if (log_data.size() != 0 || in_ready !== 1'b0 || addr !== 32'h0 || data !== 128'd0 || done !== 1'b1) begin
      fails++;
      $display("FAIL empty_refuse: got writes=%0d rdy=%b addr=%h data=%h done=%b, want 0 0 0 0 1",
               log_data.size(), in_ready, addr, data, done);
    end
  endtask

  task automatic test_reset_midload();
    do_reset();
    send_word(32'd1, 0);
    send_word(32'd0, 0);
    for (int k = 0; k < 10; k++) send_byte(8'hC0 + 8'(k), 0);
    reset = 1'b1;
    #2;
    tests++;
    if ({in_ready, addr, data, we_128, we_32, done, err} !== 166'd0) begin
      fails++;
      $display("FAIL midload_reset: got rdy=%b addr=%h data=%h we=%b%b done=%b err=%b, want all 0",
               in_ready, addr, data, we_128, we_32, done, err);
    end
    do_reset();
    send_word(32'd1, 0);
    send_word(32'd0, 0);
    for (int k = 0; k < 16; k++) send_byte(8'h10 + 8'(k), 0);
    tests++;
    if (we_128 !== 1'b1 || addr !== 32'h0 || data !== 128'h1F1E1D1C1B1A19181716151413121110 || done !== 1'b1) begin
      fails++;
      $display("FAIL midload_reload: got we128=%b addr=%h data=%h done=%b, want 1 0 1f1e..1110 1",
               we_128, addr, data, done);
    end
    idle(2);
    tests++;
    if (log_data.size() != 1 || viol != 0) begin
      fails++;
      $display("FAIL midload_writes: got writes=%0d violations=%0d, want 1 0", log_data.size(), viol);
    end
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    cyc         = 0;
    viol        = 0;
    prev_strobe = 1'b0;
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    test_reset();
    test_imem_one();
    test_dmem_two();
    test_gaps();
    test_err();
    test_empty();
    test_reset_midload();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
